dct_mdf_bfly_stage: RTL and testbench
=====================================

Name: dct_mdf_bfly_stage

Overview:
Parametrised multi-delay-feedback butterfly stage for the streaming DCT pipeline. It generalises the fixed 16-point front-end butterflies to any half-block size DELAY. It supports mirrored pairing (x_i ± x_{2D-1-i}, the DCT input fold) or linear pairing (x_i ± x_{D+i}). Additions over the fixed stages: bit growth, frame-alignment checking, and an explicit flush/drain for the last block.

Parameters:
DATA_WIDTH, 12, signed input sample width; output is DATA_WIDTH+1.
DELAY, 8, half-block length D (power of 2, ≥2); block = 2*DELAY samples.
MIRROR, 1, 1 = LIFO pairing x_i with x_{2D-1-i}; 0 = FIFO pairing x_i with x_{D+i}.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_sample  in  DATA_WIDTH  signed input sample.
in_valid  in  1  sample offered; accepted when in_valid & in_ready.
in_sop  in  1  qualifies in_sample as block sample 0.
in_ready  out  1  low only during drain.
flush  in  1  single-cycle request to drain pending differences.
out_sample  out  DATA_WIDTH+1  signed sum or difference.
out_valid  out  1  out_sample valid this cycle.
out_sop  out  1  first sum of a block.
out_diff  out  1  1 = difference word, 0 = sum word.
err_align  out  1  sticky: in_sop seen at nonzero phase.

Behaviour:
- Reset (async, rst_n=0): out_sample/out_valid/out_sop/out_diff/err_align = 0. State = S_FIRST, phase = 0, pend = 0. in_ready = 1.
- Memory: D words × (DATA_WIDTH+1), written with sign-extended raw samples (first half) or differences (second half).
- phase counter 0..2D-1, advances only on accepted samples, wraps 2D-1→0. Gaps in in_valid stall everything; outputs are unaffected except for timing.
- S_FIRST (phase < D): store sample at addr phase.
  - If pend=1, the same cycle reads diff word for position phase and drives it next cycle (out_valid=1, out_diff=1).
  - Read precedes write at the same address.
  - Entering S_SECOND clears pend.
- S_SECOND (phase = D+m): partner a = mem[D-1-m] if MIRROR, else mem[m]; b = in_sample.
  - Next cycle: out_sample = a+b, out_valid=1, out_diff=0, out_sop=1 iff m=0.
  - Write a-b back at the partner address.
  - At m=D-1, set pend=1 and return to S_FIRST.
- Output orders:
  - MIRROR=1: sums s_{D-1}..s_0, where s_i = x_i + x_{2D-1-i}; diffs d_0..d_{D-1}, where d_i = x_i - x_{2D-1-i}.
  - MIRROR=0: sums s_0..s_{D-1} and diffs d_0..d_{D-1}, where s_i = x_i + x_{D+i} and d_i = x_i - x_{D+i}.
- Latency: each output is registered 1 cycle after the accepting/reading cycle.
- S_FLUSH: entered on flush in S_FIRST with phase=0 and pend=1.
  - in_ready=0; emits D diff words on D consecutive cycles, then pend=0 → S_FIRST.
  - Flush while pend=0, phase≠0, or in S_SECOND is ignored.
  - in_valid during flush is not accepted.
- Misalignment: in_sop accepted at phase≠0 → err_align=1 (cleared only by reset), pend=0, and the sample is taken as phase 0 of a new block. Partial-block data is discarded, with no sums or diffs emitted for it.
- in_sop at phase 0 with pend=1: normal operation; diffs stream out alongside the new first half.
- Arithmetic: full precision, no saturation or rounding; DATA_WIDTH+1 bits always suffice.

Decomposition:
- Shared package dct_pkg:
  - function for address width $clog2(DELAY).
  - state encoding S_FIRST/S_SECOND/S_FLUSH.
  - localparam OUT_WIDTH = DATA_WIDTH+1.
- Sub-module dct_delay_ram: D-deep register array with one read and one write port, read-before-write, no reset on contents.

Test Plan:
- D=8, MIRROR=1, block x_i=i with in_sop, then 16 zeros: eight sums of 15 (out_sop on first). During the second block's first half, diffs -15,-13,…,-1; then eight sums 0.
- After one block (x_i=i), pulse flush: in_ready low 8 cycles, diffs -15..-1 on consecutive cycles with out_diff=1, then in_ready=1. A second flush produces no output.
- D=4, MIRROR=0, x=0..7 then flush: sums 4,6,8,10; diffs -4,-4,-4,-4.
- D=8, DATA_WIDTH=12, first half all 2047 and second half all -2048 with MIRROR=1: sums -1. Swapping the halves gives diffs -4095, and the 4095 case is also covered. All sign-correct at 13 bits.
- in_sop asserted at phase 5: err_align rises next cycle and stays set. No output from the partial block. The following 16 samples process as a clean block.
- Random in_valid gaps (50%) give the same output sequence as gapless. rst_n low mid-second-half: out_valid=0 asynchronously, and a fresh block afterwards gives correct sums.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared state encoding and sizing helpers for the streaming DCT butterfly stages.
package dct_pkg;

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_FLUSH  = 2'd2
  } dct_state_e;

  localparam int DCT_DATA_WIDTH = 12;
  localparam int OUT_WIDTH      = DCT_DATA_WIDTH + 1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int out_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/dct_delay_ram.sv
// D-deep feedback store: combinational read, registered write, so a read and a
// write to the same address in one cycle returns the old word.
module dct_delay_ram
  import dct_pkg::*;
#(
  parameter int WIDTH = OUT_WIDTH,
  parameter int DEPTH = 8,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/dct_mdf_bfly_stage.sv
// Multi-delay-feedback butterfly: buffers the first half-block, emits sums while
// the second half arrives, and streams the stored differences out afterwards.
module dct_mdf_bfly_stage
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DELAY      = 8,
  parameter bit MIRROR     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  input  logic                         in_sop,
  output logic                         in_ready,
  input  logic                         flush,
  output logic signed [DATA_WIDTH:0]   out_sample,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_diff,
  output logic                         err_align
);

  localparam int OW = out_width(DATA_WIDTH);
  localparam int AW = addr_width(DELAY);
  localparam int PW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(DELAY - 1);

  dct_state_e           state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 pend_q, pend_d;
  logic [AW-1:0]        fcnt_q, fcnt_d;
  logic signed [OW-1:0] out_sample_q, out_sample_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_diff_q, out_diff_d;
  logic                 err_align_q, err_align_d;

  logic                 flush_go;
  logic                 accept;
  logic                 misalign;
  logic [AW-1:0]        m;
  logic signed [OW-1:0] sample_ext;
  logic signed [OW-1:0] rd_data;
  logic signed [OW-1:0] sum;
  logic signed [OW-1:0] diff;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [OW-1:0]        mem_wdata;

  // The cycle that starts a drain already reads word 0, so it is not a handshake cycle.
  assign flush_go   = flush && (state_q == S_FIRST) && (phase_q == '0) && pend_q;
  assign in_ready   = (state_q != S_FLUSH) && !flush_go;
  assign accept     = in_valid && in_ready;
  assign misalign   = accept && in_sop && (phase_q != '0);
  assign m          = phase_q[AW-1:0];
  assign sample_ext = {in_sample[DATA_WIDTH-1], in_sample};
  assign sum        = rd_data + sample_ext;
  assign diff       = rd_data - sample_ext;

  always_comb begin
    mem_addr = m;
    if (state_q == S_SECOND) begin
      mem_addr = MIRROR ? (LAST - m) : m;
    end
    if (state_q == S_FLUSH) begin
      mem_addr = fcnt_q;
    end
    if (misalign) begin
      mem_addr = '0;
    end
  end

  dct_delay_ram #(
    .WIDTH (OW),
    .DEPTH (DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .raddr (mem_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pend_d       = pend_q;
    fcnt_d       = fcnt_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    out_sop_d    = 1'b0;
    out_diff_d   = 1'b0;
    err_align_d  = err_align_q;
    mem_we       = 1'b0;
    mem_wdata    = sample_ext;

    unique case (state_q)
      S_FIRST: begin
        if (flush_go) begin
          state_d      = S_FLUSH;
          fcnt_d       = AW'(1);
          out_valid_d  = 1'b1;
          out_diff_d   = 1'b1;
          out_sample_d = rd_data;
        end else if (accept) begin
          mem_we = 1'b1;
          if (misalign) begin
            err_align_d = 1'b1;
            pend_d      = 1'b0;
            phase_d     = PW'(1);
          end else begin
            if (pend_q) begin
              out_valid_d  = 1'b1;
              out_diff_d   = 1'b1;
              out_sample_d = rd_data;
            end
            phase_d = phase_q + PW'(1);
            if (m == LAST) begin
              state_d = S_SECOND;
              pend_d  = 1'b0;
            end
          end
        end
      end

      S_SECOND: begin
        if (accept) begin
          mem_we = 1'b1;
          if (misalign) begin
            err_align_d = 1'b1;
            pend_d      = 1'b0;
            phase_d     = PW'(1);
            state_d     = S_FIRST;
          end else begin
            mem_wdata    = diff;
            out_valid_d  = 1'b1;
            out_sop_d    = (m == '0);
            out_sample_d = sum;
            phase_d      = phase_q + PW'(1);
            if (m == LAST) begin
              state_d = S_FIRST;
              pend_d  = 1'b1;
            end
          end
        end
      end

      S_FLUSH: begin
        out_valid_d  = 1'b1;
        out_diff_d   = 1'b1;
        out_sample_d = rd_data;
        fcnt_d       = fcnt_q + AW'(1);
        if (fcnt_q == LAST) begin
          state_d = S_FIRST;
          pend_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FIRST;
      phase_q      <= '0;
      pend_q       <= 1'b0;
      fcnt_q       <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_diff_q   <= 1'b0;
      err_align_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      fcnt_q       <= fcnt_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_diff_q   <= out_diff_d;
      err_align_q  <= err_align_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_diff   = out_diff_q;
  assign err_align  = err_align_q;

endmodule

// File: tb/tb_dct_mdf_bfly_stage.sv
// Bench for the MDF butterfly: D=8 mirrored and D=4 linear instances checked
// against a block-level sum/difference model through expected-output queues.
module tb_dct_mdf_bfly_stage;

  typedef struct {
    logic signed [12:0] v;
    bit                 d;
    bit                 s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic signed [11:0] in8, in4;
  logic v8, v4, sop8, sop4, fl8, fl4;
  logic rdy8, rdy4;
  logic signed [12:0] os8, os4;
  logic ov8, ov4, op8, op4, od8, od4, ea8, ea4;

  int checks = 0;
  int errors = 0;
  bit ign8   = 1'b0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  int x[16];

  dct_mdf_bfly_stage #(.DATA_WIDTH(12), .DELAY(8), .MIRROR(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_sample(in8), .in_valid(v8), .in_sop(sop8),
    .in_ready(rdy8), .flush(fl8), .out_sample(os8), .out_valid(ov8),
    .out_sop(op8), .out_diff(od8), .err_align(ea8));

  dct_mdf_bfly_stage #(.DATA_WIDTH(12), .DELAY(4), .MIRROR(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_sample(in4), .in_valid(v4), .in_sop(sop4),
    .in_ready(rdy4), .flush(fl4), .out_sample(os4), .out_valid(ov4),
    .out_sop(op4), .out_diff(od4), .err_align(ea4));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Block model: pair samples by the fold rule, sums first, then differences.
  task automatic model_block(input int inst, input int xs[16]);
    int   d;
    bit   mir;
    int   i;
    int   p;
    exp_t e;
    d   = (inst == 0) ? 8 : 4;
    mir = (inst == 0);
    for (int k = 0; k < d; k++) begin
      i   = mir ? (d - 1 - k) : k;
      p   = mir ? (2 * d - 1 - i) : (d + i);
      e.v = 13'(xs[i] + xs[p]);
      e.d = 1'b0;
      e.s = (k == 0);
      if (inst == 0) q8.push_back(e); else q4.push_back(e);
    end
    for (int k = 0; k < d; k++) begin
      p   = mir ? (2 * d - 1 - k) : (d + k);
      e.v = 13'(xs[k] - xs[p]);
      e.d = 1'b1;
      e.s = 1'b0;
      if (inst == 0) q8.push_back(e); else q4.push_back(e);
    end
  endtask

  task automatic send(input int inst, input int d, input bit sop, input int gap);
    int n;
    n = 0;
    while (gap > 0 && n < 20 && $urandom_range(99) < gap) begin
      @(posedge clk); #1;
      n++;
    end
    if (inst == 0) begin
      in8 = 12'(d); sop8 = sop; v8 = 1'b1;
    end else begin
      in4 = 12'(d); sop4 = sop; v4 = 1'b1;
    end
    @(posedge clk); #1;
    v8 = 1'b0; sop8 = 1'b0; v4 = 1'b0; sop4 = 1'b0;
  endtask

  task automatic send_block(input int inst, input int xs[16], input int gap);
    int d;
    d = (inst == 0) ? 8 : 4;
    model_block(inst, xs);
    for (int i = 0; i < 2 * d; i++) send(inst, xs[i], (i == 0), gap);
  endtask

  task automatic flush_chk(input int inst, input int exp_low, input int exp_out,
                           input string tag);
    int low, nout, first, last;
    low = 0; nout = 0; first = -1; last = -1;
    @(posedge clk); #1;
    if (inst == 0) fl8 = 1'b1; else fl4 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (((inst == 0) ? rdy8 : rdy4) == 1'b0) low++;
      if ((inst == 0) ? ov8 : ov4) begin
        nout++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      fl8 = 1'b0; fl4 = 1'b0;
    end
    chk({tag, "_ready_low"}, low, exp_low);
    chk({tag, "_outputs"}, nout, exp_out);
    if (exp_out > 0) chk({tag, "_span"}, last - first + 1, exp_out);
    chk({tag, "_ready_after"}, (inst == 0) ? rdy8 : rdy4, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && !ign8 && ov8) begin
      chk("u8_output_expected", (q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("u8_sample", os8, e8.v);
        chk("u8_diff", od8, e8.d);
        chk("u8_sop", op8, e8.s);
      end
    end
    if (rst_n && ov4) begin
      chk("u4_output_expected", (q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("u4_sample", os4, e4.v);
        chk("u4_diff", od4, e4.d);
        chk("u4_sop", op4, e4.s);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in8 = '0; in4 = '0; v8 = 1'b0; v4 = 1'b0;
    sop8 = 1'b0; sop4 = 1'b0; fl8 = 1'b0; fl4 = 1'b0;
    #12;
    chk("rst_u8_valid", ov8, 0);
    chk("rst_u8_sample", os8, 0);
    chk("rst_u8_sop", op8, 0);
    chk("rst_u8_diff", od8, 0);
    chk("rst_u8_err", ea8, 0);
    chk("rst_u8_ready", rdy8, 1);
    chk("rst_u4_valid", ov4, 0);
    chk("rst_u4_ready", rdy4, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ramp block, then zeros: ramp diffs interleave with the zero block's first half
    for (int i = 0; i < 16; i++) x[i] = i;
    send_block(0, x, 0);
    for (int i = 0; i < 16; i++) x[i] = 0;
    send_block(0, x, 0);
    flush_chk(0, 8, 8, "t1_flush");
    flush_chk(0, 0, 0, "t1_reflush");

    for (int i = 0; i < 16; i++) x[i] = i;
    send_block(0, x, 0);
    flush_chk(0, 8, 8, "t2_flush");

    // linear pairing, D=4
    for (int i = 0; i < 16; i++) x[i] = (i < 8) ? i : 0;
    send_block(1, x, 0);
    flush_chk(1, 4, 4, "t3_flush");

    // full-scale extremes, both orders
    for (int i = 0; i < 16; i++) x[i] = (i < 8) ? 2047 : -2048;
    send_block(0, x, 0);
    for (int i = 0; i < 16; i++) x[i] = (i < 8) ? -2048 : 2047;
    send_block(0, x, 0);
    flush_chk(0, 8, 8, "t4_flush");

    // misaligned sop at phase 5 restarts the block
    for (int i = 0; i < 5; i++) send(0, 100 + i, (i == 0), 0);
    chk("t5_err_before", ea8, 0);
    for (int i = 0; i < 16; i++) x[i] = $urandom_range(4095) - 2048;
    model_block(0, x);
    send(0, x[0], 1'b1, 0);
    @(negedge clk);
    chk("t5_err_rise", ea8, 1);
    for (int i = 1; i < 16; i++) send(0, x[i], 1'b0, 0);
    flush_chk(0, 8, 8, "t5_flush");
    chk("t5_err_sticky", ea8, 1);
    chk("t5_u4_err", ea4, 0);

    // random data, gapless then with 50% valid gaps
    for (int i = 0; i < 16; i++) x[i] = $urandom_range(4095) - 2048;
    send_block(0, x, 0);
    send_block(0, x, 50);
    for (int i = 0; i < 16; i++) x[i] = $urandom_range(4095) - 2048;
    send_block(0, x, 50);
    flush_chk(0, 8, 8, "t6_flush");
    for (int i = 0; i < 16; i++) x[i] = $urandom_range(4095) - 2048;
    send_block(1, x, 50);
    send_block(1, x, 0);
    flush_chk(1, 4, 4, "t6_u4_flush");

    // reset while the second half is streaming
    ign8 = 1'b1;
    for (int i = 0; i < 11; i++) send(0, $urandom_range(4095) - 2048, (i == 0), 0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", ov8, 0);
    chk("t7_rst_sop", op8, 0);
    chk("t7_rst_err", ea8, 0);
    chk("t7_rst_ready", rdy8, 1);
    q8.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ign8  = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) x[i] = $urandom_range(4095) - 2048;
    send_block(0, x, 0);
    flush_chk(0, 8, 8, "t7_flush");

    chk("end_u8_queue_empty", q8.size(), 0);
    chk("end_u4_queue_empty", q4.size(), 0);
    chk("end_u4_err", ea4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "watchdog");
  end

endmodule
